register: RTL and testbench
===========================

REGISTER -- requirements
Module: register

Interface
REQ-001 Parameter: WIDTH, default 64, data bus width in bits; legal range 1 to 1024.
REQ-002 Parameter: RESET_VALUE, default all-zeros (WIDTH bits), value loaded into q while reset is asserted.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge except reset.
REQ-004 Port: reset  input  1  asynchronous reset, active-low (asserted when 0).
REQ-005 Port: en  input  1  load enable; active-high.
REQ-006 Port: d  input  WIDTH  data to load.
REQ-007 Port: q  output  WIDTH  stored value, driven directly from the storage flops.
REQ-008 Port (only when REGISTER_PARITY_EN is defined): q_par  output  1  even parity of q.

Function
REQ-009 The module SHALL store WIDTH bits in flops clocked on the rising edge of clk.
REQ-010 With reset deasserted and en=1 at a rising clk edge, q SHALL equal the d sampled at that edge, visible after that edge (one-cycle latency).
REQ-011 With reset deasserted and en=0 at a rising clk edge, q SHALL hold its previous value regardless of d.
REQ-012 Each bit SHALL be independent; no bit of d affects any other bit of q.
REQ-013 Changes on d or en between rising edges SHALL NOT affect q.
REQ-014 q SHALL have no combinational path from d or en.
REQ-015 en is don't-care while reset is asserted; q stays RESET_VALUE.

Reset
REQ-016 When reset goes to 0, q SHALL become RESET_VALUE immediately, without waiting for a clk edge.
REQ-017 While reset is 0, q SHALL remain RESET_VALUE through any number of clk edges.
REQ-018 On reset returning to 1, q SHALL keep RESET_VALUE until the first rising clk edge with en=1.
REQ-019 Reset asserted mid-operation SHALL override any pending load in the same cycle.
REQ-020 Reset SHALL apply to every bit; no flop is left unreset.

Configuration
REQ-021 Macro REGISTER_PARITY_EN: when defined, the module SHALL add an internal flop and output q_par.
REQ-022 q_par is the XOR of all bits of q.
REQ-023 q_par updates on the same edge as q.
REQ-024 q_par resets to the parity of RESET_VALUE.
REQ-025 When REGISTER_PARITY_EN is not defined, q_par and its flop SHALL NOT exist.
REQ-026 Port list, timing and all other behaviour SHALL be identical with and without the macro.

Verification
REQ-027 Reset test: reset=0, d=0, en=0, 2 clk edges -> q=0; assert reset between clock edges -> q=0 before the next edge.
REQ-028 Hold test: reset=1, en=0; walk d from 0 by setting bits 0..WIDTH-1 cumulatively, 2 edges per step -> q=0 at every step.
REQ-029 Load test: en=1; same cumulative walk of d -> q equals d after every step, ending at all-ones.
REQ-030 Hold-after-load test: load all-ones, then en=0, d=1, cumulative walk -> q stays all-ones throughout.
REQ-031 Reset-mid-operation test: with q all-ones, en=0, set reset=0 -> q=0 within the same cycle, held for 2 edges.
REQ-032 Parity test (macro defined): load 64'h1 -> q_par=1; load 64'h3 -> q_par=0; reset -> q_par=0.

Source files
------------

// File: rtl/register.sv
// register: WIDTH-bit load-enable storage register with asynchronous active-low reset.
// Optional feature: define REGISTER_PARITY_EN to add a registered even-parity output q_par.
// q (and q_par when present) come straight from flops, so there is no
// combinational path from d or en to any output.
module register #(
   parameter int unsigned      WIDTH       = 64,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
`ifdef REGISTER_PARITY_EN
   ,
   output logic             q_par
`endif
);

   // Reject unsupported widths at elaboration time.
   if (WIDTH < 1 || WIDTH > 1024) begin : g_width_check
      $error("register: WIDTH must be in the range 1 to 1024");
   end

   logic [WIDTH-1:0] q_d;

   // Next state: load d when enabled, otherwise hold.
   always_comb begin
      q_d = q;
      if (en) begin
         q_d = d;
      end
   end

   // Storage flops; reset takes effect immediately and overrides any pending load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= RESET_VALUE;
      end else begin
         q <= q_d;
      end
   end

`ifdef REGISTER_PARITY_EN
   localparam logic ResetParity = ^RESET_VALUE;

   logic q_par_q;

   // Parity is computed from the next state so it updates on the same edge as q.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_par_q <= ResetParity;
      end else begin
         q_par_q <= ^q_d;
      end
   end

   assign q_par = q_par_q;
`endif

endmodule

// File: tb/tb_register.sv
// tb_register: directed and random checks of register against a value-level model.
module tb_register;

   localparam int W  = 64;
   localparam int W2 = 8;
   localparam logic [W2-1:0] RV2 = 8'hA5;

   logic          clk = 1'b0;
   logic          reset;
   logic          en, en2;
   logic [W-1:0]  d, q;
   logic [W2-1:0] d2, q2;
`ifdef REGISTER_PARITY_EN
   logic          q_par, q_par2;
`endif

   // Model state: the value each register is expected to hold.
   logic [W-1:0]  exp_q;
   logic [W2-1:0] exp_q2;
   logic [W-1:0]  ones;
   logic [W-1:0]  saved;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   register #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .d     (d),
      .q     (q)
`ifdef REGISTER_PARITY_EN
      ,
      .q_par (q_par)
`endif
   );

   register #(.WIDTH(W2), .RESET_VALUE(RV2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .en    (en2),
      .d     (d2),
      .q     (q2)
`ifdef REGISTER_PARITY_EN
      ,
      .q_par (q_par2)
`endif
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Advance one rising edge, updating the model with the values present at that edge.
   task automatic tick();
      @(posedge clk);
      if (!reset) begin
         exp_q  = '0;
         exp_q2 = RV2;
      end else begin
         if (en)  exp_q  = d;
         if (en2) exp_q2 = d2;
      end
      #1;
   endtask

   task automatic chk_all(input string tag);
      chk(tag, q, exp_q);
      chk({tag, "_w8"}, {{(W-W2){1'b0}}, q2}, {{(W-W2){1'b0}}, exp_q2});
`ifdef REGISTER_PARITY_EN
      chk({tag, "_par"}, {{(W-1){1'b0}}, q_par}, {{(W-1){1'b0}}, ^exp_q});
      chk({tag, "_par_w8"}, {{(W-1){1'b0}}, q_par2}, {{(W-1){1'b0}}, ^exp_q2});
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end of the test");
      $fatal(1, "timeout");
   end

   initial begin
      ones = '1;
      reset = 1'b1; en = 1'b0; d = '0; en2 = 1'b0; d2 = '0;
      exp_q = '0; exp_q2 = RV2;

      // Asynchronous reset before any clock edge.
      #2 reset = 1'b0;
      #1 chk_all("rst_async");
      tick(); tick();
      chk_all("rst_hold");

      // en is ignored while reset is asserted.
      en = 1'b1; d = ones; en2 = 1'b1; d2 = 8'h3C;
      tick();
      chk_all("rst_en_ignored");
      chk("rst_en_const", q, '0);
      en = 1'b0; en2 = 1'b0;

      // Release reset: q keeps reset value until a load.
      reset = 1'b1;
      tick();
      chk_all("rel_hold");
      en = 1'b1; d = {$urandom, $urandom}; en2 = 1'b1; d2 = 8'h5A;
      tick();
      chk_all("first_load");
      // Reset between edges acts before the next edge.
      #2 reset = 1'b0;
      #1 chk("rst_between", q, '0);
      chk("rst_between_w8", {{(W-W2){1'b0}}, q2}, {{(W-W2){1'b0}}, RV2});
      tick();
      en = 1'b0; en2 = 1'b0; d = '0;
      reset = 1'b1;

      // Hold walk: en=0, cumulative d.
      for (int i = 0; i < W; i++) begin
         d[i] = 1'b1;
         tick(); tick();
         chk("hold_walk", q, exp_q);
      end
      chk("hold_walk_zero", q, '0);

      // Load walk: en=1, cumulative d.
      en = 1'b1; d = '0;
      for (int i = 0; i < W; i++) begin
         d[i] = 1'b1;
         tick(); tick();
         chk("load_walk", q, exp_q);
      end
      chk("load_walk_ones", q, ones);

      // Hold after load: en=0, d starts at 1.
      en = 1'b0; d = '0;
      for (int i = 0; i < W; i++) begin
         d[i] = 1'b1;
         tick(); tick();
         chk("hold_after_load", q, exp_q);
      end
      chk("hold_after_load_ones", q, ones);

      // Reset mid-operation with q all-ones.
      #2 reset = 1'b0;
      #1 chk("rst_mid_async", q, '0);
      tick(); tick();
      chk_all("rst_mid_hold");
      reset = 1'b1;

      // Changes between edges do not reach q.
      en = 1'b1; d = {$urandom, $urandom};
      tick();
      saved = exp_q;
      d = ~d;
      #1 chk("no_comb_path", q, saved);
      en = 1'b0;
      tick();
      chk("mid_cycle_en", q, saved);

`ifdef REGISTER_PARITY_EN
      en = 1'b1; d = 64'h1;
      tick();
      chk("par_load1", {{(W-1){1'b0}}, q_par}, 64'd1);
      d = 64'h3;
      tick();
      chk("par_load3", {{(W-1){1'b0}}, q_par}, 64'd0);
      d = 64'h7;
      tick();
      #2 reset = 1'b0;
      #1 chk("par_reset", {{(W-1){1'b0}}, q_par}, 64'd0);
      tick();
      reset = 1'b1;
      en = 1'b0;
`endif

      // Random operation with occasional asynchronous reset pulses.
      for (int n = 0; n < 300; n++) begin
         en  = 1'($urandom);
         d   = {$urandom, $urandom};
         en2 = 1'($urandom);
         d2  = 8'($urandom);
         if ($urandom_range(15) == 0) begin
            #2 reset = 1'b0;
            exp_q = '0; exp_q2 = RV2;
            #1 chk_all("rand_rst");
            tick();
            chk_all("rand_rst_edge");
            reset = 1'b1;
         end else begin
            tick();
            chk_all("rand");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
